control_unit_decode: RTL and testbench

Main control decoder of the decode stage of the scalar/vector pipelined processor. It maps the 5-bit instruction opcode to the datapath control bundle: ALU operation, operand and destination muxing, memory access, write-back, branch, and datapath-class flags. Outputs are registered and feed the decode/execute pipeline boundary.

---
 rtl/control_unit_decode.sv | 212 +++++++++++++++++++++
 tb/tb_control_unit_decode.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/control_unit_decode.sv
// Main control decoder for the decode stage: maps the 5-bit opcode to the
// datapath control bundle, registered once at the decode/execute boundary.
module control_unit_decode (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Opcode,
  output logic [3:0] ALUOp,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic       BranchOp,
  output logic       RegSrc1,
  output logic       RegSrc2,
  output logic       ALUDest,
  output logic       Vector_Op,
  output logic       PF_op,
  output logic       ImmSrc,
  output logic       Integer_op
);

  localparam logic [4:0] OP_ADDI   = 5'b01000;
  localparam logic [4:0] OP_SUBI   = 5'b01001;
  localparam logic [4:0] OP_MULI   = 5'b01010;
  localparam logic [4:0] OP_SLLI   = 5'b01011;
  localparam logic [4:0] OP_SRLI   = 5'b01100;
  localparam logic [4:0] OP_LDR    = 5'b01101;
  localparam logic [4:0] OP_STR    = 5'b01110;
  localparam logic [4:0] OP_BEQ    = 5'b01111;
  localparam logic [4:0] OP_BNE    = 5'b10000;
  localparam logic [4:0] OP_FXMUL  = 5'b10010;
  localparam logic [4:0] OP_FXADD  = 5'b10011;
  localparam logic [4:0] OP_VADD   = 5'b10100;
  localparam logic [4:0] OP_VSUB   = 5'b10101;
  localparam logic [4:0] OP_VMUL   = 5'b10110;
  localparam logic [4:0] OP_VFXMUL = 5'b10111;
  localparam logic [4:0] OP_VLDR   = 5'b11000;
  localparam logic [4:0] OP_VSTR   = 5'b11001;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MUL   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_FXMUL = 4'b1000;
  localparam logic [3:0] ALU_FXADD = 4'b1001;

  logic [3:0] alu_op_d,     alu_op_q;
  logic       reg_dst_d,    reg_dst_q;
  logic       alu_src_d,    alu_src_q;
  logic       mem_read_d,   mem_read_q;
  logic       mem_write_d,  mem_write_q;
  logic       mem_to_reg_d, mem_to_reg_q;
  logic       reg_write_d,  reg_write_q;
  logic       branch_d,     branch_q;
  logic       branch_op_d,  branch_op_q;
  logic       reg_src1_d,   reg_src1_q;
  logic       reg_src2_d,   reg_src2_q;
  logic       alu_dest_d,   alu_dest_q;
  logic       vector_op_d,  vector_op_q;
  logic       pf_op_d,      pf_op_q;
  logic       imm_src_d,    imm_src_q;
  logic       integer_op_d, integer_op_q;

  // Unassigned opcodes and NOP fall through to the all-zero defaults.
  always_comb begin
    alu_op_d     = ALU_ADD;
    reg_dst_d    = 1'b0;
    alu_src_d    = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    branch_d     = 1'b0;
    branch_op_d  = 1'b0;
    reg_src1_d   = 1'b0;
    reg_src2_d   = 1'b0;
    alu_dest_d   = 1'b0;
    vector_op_d  = 1'b0;
    pf_op_d      = 1'b0;
    imm_src_d    = 1'b0;
    integer_op_d = 1'b0;

    case (Opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011,
      5'b00100, 5'b00101, 5'b00110, 5'b00111: begin
        alu_op_d     = Opcode[3:0];
        reg_dst_d    = 1'b1;
        reg_write_d  = 1'b1;
        integer_op_d = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_SLLI, OP_SRLI: begin
        case (Opcode)
          OP_SUBI: alu_op_d = ALU_SUB;
          OP_MULI: alu_op_d = ALU_MUL;
          OP_SLLI: alu_op_d = ALU_SLL;
          OP_SRLI: alu_op_d = ALU_SRL;
          default: alu_op_d = ALU_ADD;
        endcase
        alu_src_d    = 1'b1;
        imm_src_d    = 1'b1;
        reg_write_d  = 1'b1;
        integer_op_d = 1'b1;
      end
      OP_LDR, OP_VLDR: begin
        alu_src_d    = 1'b1;
        imm_src_d    = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        integer_op_d = (Opcode == OP_LDR);
        vector_op_d  = (Opcode == OP_VLDR);
        alu_dest_d   = (Opcode == OP_VLDR);
      end
      OP_STR, OP_VSTR: begin
        alu_src_d    = 1'b1;
        imm_src_d    = 1'b1;
        mem_write_d  = 1'b1;
        reg_src2_d   = 1'b1;
        integer_op_d = (Opcode == OP_STR);
        vector_op_d  = (Opcode == OP_VSTR);
      end
      OP_BEQ, OP_BNE: begin
        alu_op_d     = ALU_SUB;
        branch_d     = 1'b1;
        branch_op_d  = (Opcode == OP_BNE);
        reg_src1_d   = 1'b1;
        imm_src_d    = 1'b1;
        integer_op_d = 1'b1;
      end
      OP_FXMUL, OP_FXADD: begin
        alu_op_d    = (Opcode == OP_FXMUL) ? ALU_FXMUL : ALU_FXADD;
        pf_op_d     = 1'b1;
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      OP_VADD, OP_VSUB, OP_VMUL, OP_VFXMUL: begin
        case (Opcode)
          OP_VSUB:   alu_op_d = ALU_SUB;
          OP_VMUL:   alu_op_d = ALU_MUL;
          OP_VFXMUL: alu_op_d = ALU_FXMUL;
          default:   alu_op_d = ALU_ADD;
        endcase
        vector_op_d = 1'b1;
        alu_dest_d  = 1'b1;
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        pf_op_d     = (Opcode == OP_VFXMUL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q     <= '0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      branch_op_q  <= 1'b0;
      reg_src1_q   <= 1'b0;
      reg_src2_q   <= 1'b0;
      alu_dest_q   <= 1'b0;
      vector_op_q  <= 1'b0;
      pf_op_q      <= 1'b0;
      imm_src_q    <= 1'b0;
      integer_op_q <= 1'b0;
    end else begin
      alu_op_q     <= alu_op_d;
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      branch_q     <= branch_d;
      branch_op_q  <= branch_op_d;
      reg_src1_q   <= reg_src1_d;
      reg_src2_q   <= reg_src2_d;
      alu_dest_q   <= alu_dest_d;
      vector_op_q  <= vector_op_d;
      pf_op_q      <= pf_op_d;
      imm_src_q    <= imm_src_d;
      integer_op_q <= integer_op_d;
    end
  end

  assign ALUOp      = alu_op_q;
  assign RegDst     = reg_dst_q;
  assign ALUSrc     = alu_src_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign MemtoReg   = mem_to_reg_q;
  assign RegWrite   = reg_write_q;
  assign Branch     = branch_q;
  assign BranchOp   = branch_op_q;
  assign RegSrc1    = reg_src1_q;
  assign RegSrc2    = reg_src2_q;
  assign ALUDest    = alu_dest_q;
  assign Vector_Op  = vector_op_q;
  assign PF_op      = pf_op_q;
  assign ImmSrc     = imm_src_q;
  assign Integer_op = integer_op_q;

endmodule

// File: tb/tb_control_unit_decode.sv
// Scoreboard bench for control_unit_decode: stimulus pushes the hand-derived
// bundle for each opcode, a monitor pops and compares one cycle later.
module tb_control_unit_decode;

  logic       clk;
  logic       rst;
  logic [4:0] Opcode;
  logic [3:0] ALUOp;
  logic RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch, BranchOp;
  logic RegSrc1, RegSrc2, ALUDest, Vector_Op, PF_op, ImmSrc, Integer_op;

  typedef struct packed {
    logic [3:0] alu;
    logic reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic branch, branch_op, reg_src1, reg_src2, alu_dest, vector_op;
    logic pf_op, imm_src, integer_op;
  } ctrl_t;

  typedef struct packed {
    logic [4:0] op;
    ctrl_t      exp;
  } item_t;

  item_t sb_q[$];
  int    errors = 0;
  int    checks = 0;
  ctrl_t dut_bus;

  control_unit_decode dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .ALUOp(ALUOp),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch), .BranchOp(BranchOp),
    .RegSrc1(RegSrc1), .RegSrc2(RegSrc2), .ALUDest(ALUDest), .Vector_Op(Vector_Op),
    .PF_op(PF_op), .ImmSrc(ImmSrc), .Integer_op(Integer_op)
  );

  assign dut_bus = {ALUOp, RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite,
                    Branch, BranchOp, RegSrc1, RegSrc2, ALUDest, Vector_Op,
                    PF_op, ImmSrc, Integer_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written decode table used as the reference.
  function automatic ctrl_t exp_of(input logic [4:0] op);
    ctrl_t e;
    e = '0;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: begin
        e.alu = op[3:0]; e.reg_dst = 1; e.reg_write = 1; e.integer_op = 1;
      end
      5'd8, 5'd9, 5'd10, 5'd11, 5'd12: begin
        e.alu = (op == 5'd8) ? 4'h0 : (op == 5'd9) ? 4'h1 : (op == 5'd10) ? 4'h2 :
                (op == 5'd11) ? 4'h6 : 4'h7;
        e.alu_src = 1; e.imm_src = 1; e.reg_write = 1; e.integer_op = 1;
      end
      5'd13: begin
        e.alu_src = 1; e.imm_src = 1; e.mem_read = 1; e.mem_to_reg = 1;
        e.reg_write = 1; e.integer_op = 1;
      end
      5'd14: begin
        e.alu_src = 1; e.imm_src = 1; e.mem_write = 1; e.reg_src2 = 1; e.integer_op = 1;
      end
      5'd15, 5'd16: begin
        e.alu = 4'h1; e.branch = 1; e.branch_op = (op == 5'd16);
        e.reg_src1 = 1; e.imm_src = 1; e.integer_op = 1;
      end
      5'd18, 5'd19: begin
        e.alu = (op == 5'd18) ? 4'h8 : 4'h9; e.pf_op = 1; e.reg_dst = 1; e.reg_write = 1;
      end
      5'd20, 5'd21, 5'd22, 5'd23: begin
        e.alu = (op == 5'd20) ? 4'h0 : (op == 5'd21) ? 4'h1 : (op == 5'd22) ? 4'h2 : 4'h8;
        e.vector_op = 1; e.alu_dest = 1; e.reg_dst = 1; e.reg_write = 1;
        e.pf_op = (op == 5'd23);
      end
      5'd24: begin
        e.vector_op = 1; e.alu_dest = 1; e.alu_src = 1; e.imm_src = 1;
        e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1;
      end
      5'd25: begin
        e.vector_op = 1; e.alu_src = 1; e.imm_src = 1; e.mem_write = 1; e.reg_src2 = 1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic apply(input logic [4:0] op);
    item_t it;
    @(negedge clk);
    Opcode = op;
    it.op  = op;
    it.exp = exp_of(op);
    sb_q.push_back(it);
    @(posedge clk);
  endtask

  // Monitor: outputs are valid one cycle after the opcode was presented.
  always @(posedge clk) begin
    item_t it;
    int cls;
    #1;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check($sformatf("bundle op=%b", it.op), 32'(dut_bus), 32'(it.exp));
      check($sformatf("rd_wr_excl op=%b", it.op), 32'(MemRead & MemWrite), 32'd0);
      check($sformatf("memtoreg_impl op=%b", it.op), 32'(MemtoReg & ~MemRead), 32'd0);
      check($sformatf("branch_nowr op=%b", it.op), 32'(Branch & RegWrite), 32'd0);
      cls = int'(Integer_op) + int'(Vector_Op) + int'(PF_op & ~Vector_Op);
      check($sformatf("class_onehot op=%b", it.op), 32'(cls), (it.exp != '0) ? 32'd1 : 32'd0);
    end
  end

  initial begin
    ctrl_t held;
    rst    = 1'b1;
    Opcode = 5'b00000;
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", 32'(dut_bus), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    apply(5'b00000);
    apply(5'b01101);
    apply(5'b01110);
    apply(5'b01111);
    apply(5'b10000);
    apply(5'b10111);
    apply(5'b11000);
    apply(5'b10001);
    apply(5'b11010);
    apply(5'b11111);

    // Opcode changing mid-cycle must not disturb the registered outputs.
    apply(5'b00011);
    #2 Opcode = 5'b01110;
    #1 begin
      held = exp_of(5'b00011);
      check("hold_between_edges", 32'(dut_bus), 32'(held));
    end

    // Asynchronous reset between edges clears the bundle immediately.
    apply(5'b00101);
    #3 rst = 1'b1;
    #1 check("async_reset", 32'(dut_bus), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    Opcode = 5'b00101;
    begin
      item_t it;
      it.op = 5'b00101; it.exp = exp_of(5'b00101);
      sb_q.push_back(it);
    end
    @(posedge clk);

    for (int i = 0; i < 32; i++) apply(i[4:0]);

    repeat (2) @(posedge clk);
    #2 check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
